bus_scratch_ram: RTL and testbench

//  Word-addressed scratchpad RAM, a slave on the shared OR-combined bus, downstream of CpuBusMaster.

---
 rtl/bus_pkg.sv | 33 +++
 rtl/scratch_ram_bank.sv | 27 ++
 rtl/bus_scratch_ram.sv | 143 ++++++++++++++
 tb/tb_bus_scratch_ram.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus field widths, scratch RAM FSM states and OR-bus output helpers.
package bus_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned BURST_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_FETCH,
    RD_BEAT,
    WR_BEAT,
    ERR,
    ERR_DRAIN
  } ramState_t;

  typedef struct packed {
    logic endTxn;
    logic dataValid;
    logic busy;
    logic error;
  } busCtrl_t;

  function automatic busCtrl_t busCtrlIdle();
    return '0;
  endfunction

  // Data lanes must be zero whenever this slave is not driving a beat.
  function automatic logic [ADDR_W-1:0] orBusGate(input logic drive, input logic [ADDR_W-1:0] d);
    return drive ? d : '0;
  endfunction

endpackage

// File: rtl/scratch_ram_bank.sv
// Single-port synchronous RAM, 2**WORDS_LOG2 x 32, per-byte write enables, 1-cycle read latency.
module scratch_ram_bank
  import bus_pkg::*;
#(
  parameter int unsigned WORDS_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [WORDS_LOG2-1:0] addr,
  input  logic [BE_W-1:0]       wrEn,
  input  logic [ADDR_W-1:0]     wrData,
  output logic [ADDR_W-1:0]     rdData
);

  // One byte-wide array per lane keeps each lane's write port independent.
  for (genvar lane = 0; lane < BE_W; lane++) begin : gLane
    logic [7:0] laneMem [2**WORDS_LOG2];
    logic [7:0] laneQ;

    always_ff @(posedge clk) begin
      if (wrEn[lane]) laneMem[addr] <= wrData[lane*8 +: 8];
      laneQ <= laneMem[addr];
    end

    assign rdData[lane*8 +: 8] = laneQ;
  end

endmodule

// File: rtl/bus_scratch_ram.sv
// Scratchpad RAM slave on the OR-combined bus: single/burst reads and byte-enabled writes.
module bus_scratch_ram
  import bus_pkg::*;
#(
  parameter logic [31:0]  BASE_ADDR  = 32'h0001_0000,
  parameter int unsigned  WORDS_LOG2 = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  bus_addrData_i,
  input  logic [BE_W-1:0]    bus_byteEnables_i,
  input  logic [BURST_W-1:0] bus_burstSize_i,
  input  logic               bus_readNWrite_i,
  input  logic               bus_beginTransaction_i,
  input  logic               bus_endTransaction_i,
  input  logic               bus_dataValid_i,
  output logic [ADDR_W-1:0]  bus_addrData_o,
  output logic               bus_endTransaction_o,
  output logic               bus_dataValid_o,
  output logic               bus_busy_o,
  output logic               bus_error_o
);

  localparam int unsigned TAG_LSB = WORDS_LOG2 + 2;
  localparam logic [32:0] WORDS   = 33'd1 << WORDS_LOG2;

  ramState_t             state, nextState;
  busCtrl_t              ctrlR, ctrlNext;
  logic [WORDS_LOG2-1:0] wordIdx;
  logic [BURST_W-1:0]    burstR;
  logic [BE_W-1:0]       beR;
  logic                  isRead;
  logic [8:0]            cnt;
  logic [BE_W-1:0]       ramWe;
  logic [ADDR_W-1:0]     ramQ;

  logic [WORDS_LOG2-1:0] reqIdx;
  logic [32:0]           reqSpan;
  logic                  hit, reqErr, moreBeats, lastIssue;

  assign reqIdx    = bus_addrData_i[TAG_LSB-1:2];
  assign hit       = bus_beginTransaction_i &&
                     (bus_addrData_i[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
  assign reqSpan   = 33'(reqIdx) + 33'(bus_burstSize_i);
  assign reqErr    = (bus_addrData_i[1:0] != 2'b00) || (bus_burstSize_i == '0) || (reqSpan > WORDS);
  assign moreBeats = {1'b0, burstR} > cnt;
  assign lastIssue = (cnt + 9'd1) == {1'b0, burstR};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (hit) nextState = reqErr ? ERR : (bus_readNWrite_i ? RD_FETCH : WR_BEAT);
      RD_FETCH:  nextState = RD_BEAT;
      RD_BEAT:   if (!moreBeats) nextState = IDLE;
      WR_BEAT:   if (bus_endTransaction_i) nextState = IDLE;
      // A rejected write may already carry its end beat while the error is on the bus.
      ERR:       nextState = (isRead || bus_endTransaction_i) ? IDLE : ERR_DRAIN;
      ERR_DRAIN: if (bus_endTransaction_i) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    ctrlNext      = busCtrlIdle();
    ctrlNext.busy = (state != IDLE) || (nextState != IDLE);
    unique case (state)
      IDLE: if (hit && reqErr) begin
        ctrlNext.error  = 1'b1;
        ctrlNext.endTxn = 1'b1;
      end
      RD_FETCH: begin
        ctrlNext.dataValid = 1'b1;
        ctrlNext.endTxn    = (burstR == 8'd1);
      end
      RD_BEAT: if (moreBeats) begin
        ctrlNext.dataValid = 1'b1;
        ctrlNext.endTxn    = lastIssue;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ctrlR <= busCtrlIdle();
    else        ctrlR <= ctrlNext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wordIdx <= '0;
      burstR  <= '0;
      beR     <= '0;
      isRead  <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: if (hit) begin
          wordIdx <= reqIdx;
          burstR  <= bus_burstSize_i;
          beR     <= bus_byteEnables_i;
          isRead  <= bus_readNWrite_i;
          cnt     <= '0;
        end
        RD_FETCH: begin
          wordIdx <= wordIdx + WORDS_LOG2'(1);
          cnt     <= cnt + 9'd1;
        end
        RD_BEAT: if (moreBeats) begin
          wordIdx <= wordIdx + WORDS_LOG2'(1);
          cnt     <= cnt + 9'd1;
        end
        WR_BEAT: if (bus_dataValid_i && moreBeats) begin
          wordIdx <= wordIdx + WORDS_LOG2'(1);
          cnt     <= cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

  assign ramWe = (state == WR_BEAT && bus_dataValid_i && moreBeats) ? beR : '0;

  scratch_ram_bank #(.WORDS_LOG2(WORDS_LOG2)) u_bank (
    .clk    (clk),
    .addr   (wordIdx),
    .wrEn   (ramWe),
    .wrData (bus_addrData_i),
    .rdData (ramQ)
  );

  // Read data comes straight from the bank's output register, qualified by the registered valid.
  assign bus_addrData_o       = orBusGate(ctrlR.dataValid, ramQ);
  assign bus_endTransaction_o = ctrlR.endTxn;
  assign bus_dataValid_o      = ctrlR.dataValid;
  assign bus_busy_o           = ctrlR.busy;
  assign bus_error_o          = ctrlR.error;

endmodule

// File: tb/tb_bus_scratch_ram.sv
// Randomized bench for bus_scratch_ram against a per-cycle expected-output timeline and word-array model.
module tb_bus_scratch_ram;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          WL2   = 10;
  localparam int          WORDS = 1024;
  localparam int          NCYC  = 12000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addrData_i;
  logic [3:0]  byteEnables_i;
  logic [7:0]  burstSize_i;
  logic        readNWrite_i, begin_i, end_i, dataValid_i;
  logic [31:0] addrData_o;
  logic        end_o, dataValid_o, busy_o, error_o;

  bus_scratch_ram #(.BASE_ADDR(BASE), .WORDS_LOG2(WL2)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus_addrData_i         (addrData_i),
    .bus_byteEnables_i      (byteEnables_i),
    .bus_burstSize_i        (burstSize_i),
    .bus_readNWrite_i       (readNWrite_i),
    .bus_beginTransaction_i (begin_i),
    .bus_endTransaction_i   (end_i),
    .bus_dataValid_i        (dataValid_i),
    .bus_addrData_o         (addrData_o),
    .bus_endTransaction_o   (end_o),
    .bus_dataValid_o        (dataValid_o),
    .bus_busy_o             (busy_o),
    .bus_error_o            (error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Packed output word: {data[35:4], end[3], dataValid[2], busy[1], error[0]}
  logic [35:0] expv  [NCYC];
  logic [35:0] seenv [NCYC];
  logic [31:0] mem   [WORDS];
  logic [31:0] wbuf  [300];
  int          assertions = 0;
  int          failures   = 0;
  bit          chkEn      = 1'b0;
  logic [35:0] act;

  function automatic logic [35:0] L(input logic [31:0] d, input logic e, input logic v,
                                    input logic b, input logic r);
    return {d, e, v, b, r};
  endfunction

  always @(negedge clk) begin
    if (chkEn && cyc < NCYC) begin
      act = {addrData_o, end_o, dataValid_o, busy_o, error_o};
      seenv[cyc] = act;
      assertions++;
      if (act !== expv[cyc]) begin
        failures++;
        $display("FAIL cycle%0d outputs: got data=%h end=%b dv=%b busy=%b err=%b, want data=%h end=%b dv=%b busy=%b err=%b",
                 cyc, act[35:4], act[3], act[2], act[1], act[0],
                 expv[cyc][35:4], expv[cyc][3], expv[cyc][2], expv[cyc][1], expv[cyc][0]);
      end
    end
  end

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
    assertions++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit hitOf(input logic [31:0] a);
    return (a >> (WL2 + 2)) == (BASE >> (WL2 + 2));
  endfunction

  function automatic bit errOf(input logic [31:0] a, input int b);
    int idx;
    idx = int'((a >> 2) % WORDS);
    return (a[1:0] != 2'b00) || (b == 0) || (idx + b > WORDS);
  endfunction

  task automatic setBusy(input int c);
    if (c < NCYC) expv[c][1] = 1'b1;
  endtask

  task automatic idleIn();
    begin_i      = 1'b0;
    end_i        = 1'b0;
    dataValid_i  = 1'b0;
    addrData_i   = $urandom;
    readNWrite_i = 1'($urandom);
  endtask

  task automatic doRead(input logic [31:0] a, input int b, input bit stray, output int T);
    bit h, e;
    int idx, len;
    T = cyc;
    h = hitOf(a);
    e = errOf(a, b);
    idx = int'((a >> 2) % WORDS);
    begin_i = 1'b1; addrData_i = a; burstSize_i = 8'(b); readNWrite_i = 1'b1;
    byteEnables_i = 4'($urandom); dataValid_i = 1'b0; end_i = 1'b0;
    len = 0;
    if (h && e) begin
      expv[T+1] = L(32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      setBusy(T + 2);
      len = 2;
    end else if (h) begin
      for (int c = T + 1; c <= T + b + 2; c++) setBusy(c);
      for (int k = 1; k <= b; k++) begin
        expv[T+1+k][35:4] = mem[idx+k-1];
        expv[T+1+k][3]    = (k == b);
        expv[T+1+k][2]    = 1'b1;
      end
      len = b + 2;
    end
    tick();
    idleIn();
    while (cyc < T + len + 1) begin
      if (stray && h && !e && cyc == T + 2) begin
        begin_i = 1'b1; addrData_i = BASE; burstSize_i = 8'd1;
      end else begin
        begin_i = 1'b0;
      end
      tick();
    end
    idleIn();
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [3:0] be, input int b, input int nb,
                         input bit gaps, output int T);
    bit h, e;
    int idx, g;
    logic [31:0] mask;
    T = cyc;
    h = hitOf(a);
    e = errOf(a, b);
    idx = int'((a >> 2) % WORDS);
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    begin_i = 1'b1; addrData_i = a; burstSize_i = 8'(b); readNWrite_i = 1'b0;
    byteEnables_i = be; dataValid_i = 1'b0; end_i = 1'b0;
    if (h && e) begin
      expv[T+1][3] = 1'b1;
      expv[T+1][0] = 1'b1;
    end
    tick();
    begin_i = 1'b0;
    byteEnables_i = 4'($urandom);
    burstSize_i = 8'($urandom);
    for (int i = 0; i < nb; i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      for (int j = 0; j < g; j++) begin
        dataValid_i = 1'b0; end_i = 1'b0; addrData_i = $urandom;
        if (h) setBusy(cyc);
        tick();
      end
      dataValid_i = 1'b1; addrData_i = wbuf[i]; end_i = (i == nb - 1);
      if (h) setBusy(cyc);
      if (h && !e && i < b) mem[idx+i] = (mem[idx+i] & ~mask) | (wbuf[i] & mask);
      tick();
    end
    idleIn();
    if (h) setBusy(cyc);
    tick();
  endtask

  task automatic doResetRead(input logic [31:0] a, output int T);
    int idx;
    T = cyc;
    idx = int'((a >> 2) % WORDS);
    begin_i = 1'b1; addrData_i = a; burstSize_i = 8'd4; readNWrite_i = 1'b1;
    for (int c = T + 1; c <= T + 3; c++) setBusy(c);
    expv[T+2][35:4] = mem[idx];   expv[T+2][2] = 1'b1;
    expv[T+3][35:4] = mem[idx+1]; expv[T+3][2] = 1'b1;
    tick();
    idleIn();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int T, T2, r, idx, b, nb;
    logic [31:0] a;
    for (int c = 0; c < NCYC; c++) expv[c] = '0;
    rst_n = 1'b0;
    byteEnables_i = '0; burstSize_i = '0;
    idleIn();
    tick();
    chkEn = 1'b1;
    tick();
    tick();
    chk("reset_state", seenv[cyc-1], 36'h0);
    rst_n = 1'b1;
    tick();

    // Fill the whole array so every later read has defined contents.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 255; i++) wbuf[i] = $urandom;
      doWrite(BASE + 32'(k * 255 * 4), 4'hF, 255, 255, 1'b0, T);
    end
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    doWrite(BASE + 32'(1020 * 4), 4'hF, 4, 4, 1'b0, T);

    wbuf[0] = 32'hDEADBEEF;
    doWrite(32'h0001_0010, 4'hF, 1, 1, 1'b0, T);
    doRead(32'h0001_0010, 1, 1'b0, T);
    tick();
    chk("single_rd_beat", seenv[T+2], L(32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0));

    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    doWrite(32'h0001_0000, 4'hF, 4, 4, 1'b1, T);
    doRead(32'h0001_0000, 4, 1'b1, T);
    tick();
    chk("burst_beat1", seenv[T+2], L(32'd1, 1'b0, 1'b1, 1'b1, 1'b0));
    chk("burst_beat2", seenv[T+3], L(32'd2, 1'b0, 1'b1, 1'b1, 1'b0));
    chk("burst_beat3", seenv[T+4], L(32'd3, 1'b0, 1'b1, 1'b1, 1'b0));
    chk("burst_beat4", seenv[T+5], L(32'd4, 1'b1, 1'b1, 1'b1, 1'b0));
    chk("burst_tail",  seenv[T+6], L(32'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    chk("burst_done",  seenv[T+7], 36'h0);

    wbuf[0] = 32'h1111_1111;
    doWrite(32'h0001_0020, 4'hF, 1, 1, 1'b0, T);
    wbuf[0] = 32'hAABB_CCDD;
    doWrite(32'h0001_0020, 4'b0101, 1, 1, 1'b0, T);
    doRead(32'h0001_0020, 1, 1'b0, T);
    tick();
    chk("byte_enable", seenv[T+2], L(32'h11BB_11DD, 1'b1, 1'b1, 1'b1, 1'b0));

    doRead(32'h0001_0FFC, 2, 1'b0, T);
    tick();
    chk("range_err", seenv[T+1], L(32'h0, 1'b1, 1'b0, 1'b1, 1'b1));
    chk("range_err_after", seenv[T+2], L(32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    doRead(32'h0001_0FFC, 1, 1'b0, T);

    wbuf[0] = 32'hCAFE_F00D;
    doWrite(32'h0001_0002, 4'hF, 1, 1, 1'b0, T);
    tick();
    chk("misalign_err", seenv[T+1], L(32'h0, 1'b1, 1'b0, 1'b1, 1'b1));
    doRead(32'h0001_0000, 1, 1'b0, T);
    tick();
    chk("misalign_kept", seenv[T+2], L(32'd1, 1'b1, 1'b1, 1'b1, 1'b0));

    doRead(32'h0002_0000, 1, 1'b0, T);
    tick();
    chk("miss_t1", seenv[T+1], 36'h0);
    chk("miss_t2", seenv[T+2], 36'h0);
    wbuf[0] = 32'h5555_AAAA;
    doWrite(32'h0002_0000, 4'hF, 1, 1, 1'b0, T);

    doResetRead(32'h0001_0000, T);
    chk("reset_mid_read", seenv[T+4], 36'h0);
    doRead(32'h0001_0000, 4, 1'b0, T2);
    tick();
    chk("post_reset_data", seenv[T2+5], L(32'd4, 1'b1, 1'b1, 1'b1, 1'b0));

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      idx = $urandom_range(0, WORDS - 1);
      b = $urandom_range(0, 6);
      if (r == 2) begin
        idx = WORDS - $urandom_range(1, 4);
        b = $urandom_range(1, 6);
      end
      a = BASE + 32'(idx * 4);
      if (r == 0) a = 32'h0002_0000 + 32'(idx * 4);
      if (r == 1) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        doRead(a, b, 1'($urandom), T);
      end else begin
        nb = $urandom_range(1, b + 2);
        for (int i = 0; i < nb; i++) wbuf[i] = $urandom;
        doWrite(a, 4'($urandom), b, nb, 1'b1, T);
      end
    end
    for (int k = 0; k < 4; k++) doRead(BASE + 32'(k * 255 * 4), 255, 1'b0, T);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
